qs_stack_mc: RTL and testbench

- Multi-channel LIFO for the quicksort datapath.
- Holds C independent stacks, each N entries of W bits, in one shared single-port SRAM (C*N words).
- Accepts at most one command per cycle on any channel.
- Pop/peek data returns on a registered response port one cycle later.
- Successor to the single-channel stack: adds channel count, per-channel occupancy, per-channel clear and error reporting.

---
 rtl/qs_stack_mc.sv | 153 +++++++++++++++
 tb/tb_qs_stack_mc.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/qs_stack_mc.sv
// qs_stack_mc: multi-channel LIFO for the quicksort datapath.
// C independent stacks of N x W-bit entries share one single-port SRAM of C*N
// words. Entry i of channel c lives at address c*N + i. At most one command is
// accepted per cycle. Pop/peek data appears on the registered response port one
// cycle after the command.
//
// Ports:
//   clk, rst      clock; synchronous active-low reset
//   cmd_vld       command valid (no backpressure)
//   cmd_ch        target channel
//   cmd_op        00 push, 01 pop, 10 clear, 11 peek (or error when disabled)
//   cmd_push_dat  push data
//   cmd_err_w     combinational: current command is illegal and ignored
//   rsp_vld_r     registered one-cycle response strobe
//   rsp_ch_r      registered response channel
//   rsp_dat_r     registered popped/peeked word, held until the next response
//   empty_r       per-channel empty flags
//   full_r        per-channel full flags
//   cnt_r         per-channel occupancy, channel c at [c*CW +: CW]
//
// Optional feature: define QS_STACK_MC_PEEK_EN to enable op 11 as peek.
module qs_stack_mc #(
    parameter  int C   = 4,
    parameter  int N   = 16,
    parameter  int W   = 32,
    localparam int CHW = (C > 1) ? $clog2(C) : 1,
    localparam int CW  = $clog2(N + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_vld,
    input  logic [CHW-1:0]    cmd_ch,
    input  logic [1:0]        cmd_op,
    input  logic [W-1:0]      cmd_push_dat,
    output logic              cmd_err_w,
    output logic              rsp_vld_r,
    output logic [CHW-1:0]    rsp_ch_r,
    output logic [W-1:0]      rsp_dat_r,
    output logic [C-1:0]      empty_r,
    output logic [C-1:0]      full_r,
    output logic [C*CW-1:0]   cnt_r
);

    localparam int AW = (C * N > 1) ? $clog2(C * N) : 1;

    typedef enum logic [1:0] {
        OP_PUSH  = 2'b00,
        OP_POP   = 2'b01,
        OP_CLEAR = 2'b10,
        OP_PEEK  = 2'b11
    } op_e;

    logic [W-1:0]   mem [C*N];

    logic           ch_ok;
    logic [CHW-1:0] ch_idx;
    logic [CW-1:0]  cur_cnt;
    logic [CW-1:0]  cnt_nxt;
    logic [AW-1:0]  wr_addr;
    logic [AW-1:0]  rd_addr;
    logic           do_wr;
    logic           do_rd;
    logic           upd;
    logic           err;

    // Command decode. An out-of-range channel is steered to 0 so array
    // indexing stays in bounds; the command is flagged as an error anyway.
    always_comb begin
        ch_ok   = (32'(cmd_ch) < C);
        ch_idx  = ch_ok ? cmd_ch : '0;
        cur_cnt = cnt_r[32'(ch_idx)*CW +: CW];
        wr_addr = AW'(32'(ch_idx) * N + 32'(cur_cnt));
        rd_addr = AW'(32'(ch_idx) * N + 32'(cur_cnt) - 1);
        cnt_nxt = cur_cnt;
        do_wr   = 1'b0;
        do_rd   = 1'b0;
        upd     = 1'b0;
        err     = 1'b0;
        if (cmd_vld) begin
            if (!ch_ok) begin
                err = 1'b1;
            end else begin
                case (op_e'(cmd_op))
                    OP_PUSH: begin
                        if (full_r[ch_idx]) begin
                            err = 1'b1;
                        end else begin
                            do_wr   = 1'b1;
                            upd     = 1'b1;
                            cnt_nxt = cur_cnt + CW'(1);
                        end
                    end
                    OP_POP: begin
                        if (empty_r[ch_idx]) begin
                            err = 1'b1;
                        end else begin
                            do_rd   = 1'b1;
                            upd     = 1'b1;
                            cnt_nxt = cur_cnt - CW'(1);
                        end
                    end
                    OP_CLEAR: begin
                        upd     = 1'b1;
                        cnt_nxt = '0;
                    end
                    OP_PEEK: begin
`ifdef QS_STACK_MC_PEEK_EN
                        if (empty_r[ch_idx]) begin
                            err = 1'b1;
                        end else begin
                            do_rd = 1'b1;
                        end
`else
                        err = 1'b1;
`endif
                    end
                    default: err = 1'b1;
                endcase
            end
        end
        cmd_err_w = err;
    end

    // SRAM write port; contents survive reset, only the counts are cleared.
    always_ff @(posedge clk) begin
        if (rst && do_wr) begin
            mem[wr_addr] <= cmd_push_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_r     <= '0;
            empty_r   <= '1;
            full_r    <= '0;
            rsp_vld_r <= 1'b0;
            rsp_ch_r  <= '0;
            rsp_dat_r <= '0;
        end else begin
            rsp_vld_r <= do_rd;
            if (do_rd) begin
                rsp_ch_r  <= ch_idx;
                rsp_dat_r <= mem[rd_addr];
            end
            if (upd) begin
                cnt_r[32'(ch_idx)*CW +: CW] <= cnt_nxt;
                empty_r[ch_idx]             <= (cnt_nxt == '0);
                full_r[ch_idx]              <= (cnt_nxt == CW'(N));
            end
        end
    end

endmodule

// File: tb/tb_qs_stack_mc.sv
// tb_qs_stack_mc: self-checking bench for qs_stack_mc (C=4, N=16, W=32).
// A reference stack model predicts errors, occupancy and flags; expected
// responses are queued when a pop/peek is issued and compared when the DUT
// raises rsp_vld_r. Honours QS_STACK_MC_PEEK_EN like the design.
module tb_qs_stack_mc;

    localparam int C  = 4;
    localparam int N  = 16;
    localparam int W  = 32;
    localparam int CW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_vld;
    logic [1:0]    cmd_ch;
    logic [1:0]    cmd_op;
    logic [W-1:0]  cmd_push_dat;
    logic          cmd_err_w;
    logic          rsp_vld_r;
    logic [1:0]    rsp_ch_r;
    logic [W-1:0]  rsp_dat_r;
    logic [C-1:0]  empty_r;
    logic [C-1:0]  full_r;
    logic [C*CW-1:0] cnt_r;

    qs_stack_mc #(.C(C), .N(N), .W(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_vld      (cmd_vld),
        .cmd_ch       (cmd_ch),
        .cmd_op       (cmd_op),
        .cmd_push_dat (cmd_push_dat),
        .cmd_err_w    (cmd_err_w),
        .rsp_vld_r    (rsp_vld_r),
        .rsp_ch_r     (rsp_ch_r),
        .rsp_dat_r    (rsp_dat_r),
        .empty_r      (empty_r),
        .full_r       (full_r),
        .cnt_r        (cnt_r)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    logic [33:0] sb [$];
    logic [31:0] mstk [C][N];
    int          mcnt [C];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_state();
        for (int c = 0; c < C; c++) begin
            chk("cnt",   32'(cnt_r[c*CW +: CW]), 32'(mcnt[c]));
            chk("empty", 32'(empty_r[c]), 32'(mcnt[c] == 0));
            chk("full",  32'(full_r[c]),  32'(mcnt[c] == N));
        end
    endtask

    // Issue one command for one cycle; model predicts legality and effects.
    task automatic do_cmd(input int ch, input logic [1:0] op, input logic [31:0] dat);
        logic e;
        @(negedge clk);
        cmd_vld      = 1'b1;
        cmd_ch       = 2'(ch);
        cmd_op       = op;
        cmd_push_dat = dat;
        case (op)
            2'b00:   e = (mcnt[ch] == N);
            2'b01:   e = (mcnt[ch] == 0);
            2'b10:   e = 1'b0;
`ifdef QS_STACK_MC_PEEK_EN
            default: e = (mcnt[ch] == 0);
`else
            default: e = 1'b1;
`endif
        endcase
        #1;
        chk("cmd_err", 32'(cmd_err_w), 32'(e));
        if (!e) begin
            case (op)
                2'b00: begin
                    mstk[ch][mcnt[ch]] = dat;
                    mcnt[ch]++;
                end
                2'b01: begin
                    sb.push_back({2'(ch), mstk[ch][mcnt[ch]-1]});
                    mcnt[ch]--;
                end
                2'b10: mcnt[ch] = 0;
                default: sb.push_back({2'(ch), mstk[ch][mcnt[ch]-1]});
            endcase
        end
        @(posedge clk);
        #1;
        cmd_vld = 1'b0;
        check_state();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cmd_vld = 1'b0;
            cmd_ch  = 2'd1;
            cmd_op  = 2'b01;
            #1;
            chk("err_idle", 32'(cmd_err_w), 32'd0);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst     = 1'b0;
        cmd_vld = 1'b0;
        @(posedge clk);
        #1;
        for (int c = 0; c < C; c++) mcnt[c] = 0;
        chk("rst_cnt",   32'(cnt_r), 32'd0);
        chk("rst_empty", 32'(empty_r), 32'hF);
        chk("rst_full",  32'(full_r), 32'd0);
        chk("rst_vld",   32'(rsp_vld_r), 32'd0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Response scoreboard.
    always @(negedge clk) begin
        if (rsp_vld_r === 1'b1) begin
            if (sb.size() == 0) begin
                chk("spurious_rsp", 32'd1, 32'd0);
            end else begin
                logic [33:0] x;
                x = sb.pop_front();
                chk("rsp_ch",  32'(rsp_ch_r), 32'(x[33:32]));
                chk("rsp_dat", rsp_dat_r, x[31:0]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] held;
        rst          = 1'b0;
        cmd_vld      = 1'b0;
        cmd_ch       = '0;
        cmd_op       = '0;
        cmd_push_dat = '0;
        for (int c = 0; c < C; c++) mcnt[c] = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_cnt",   32'(cnt_r), 32'd0);
        chk("reset_empty", 32'(empty_r), 32'hF);
        chk("reset_full",  32'(full_r), 32'd0);
        chk("reset_vld",   32'(rsp_vld_r), 32'd0);
        chk("reset_ch",    32'(rsp_ch_r), 32'd0);
        chk("reset_dat",   rsp_dat_r, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Three pushes then three back-to-back pops on channel 2.
        do_cmd(2, 2'b00, 32'hA);
        do_cmd(2, 2'b00, 32'hB);
        do_cmd(2, 2'b00, 32'hC);
        do_cmd(2, 2'b01, 0);
        do_cmd(2, 2'b01, 0);
        do_cmd(2, 2'b01, 0);
        idle(2);
        chk("ch2_empty", 32'(empty_r[2]), 32'd1);
        chk("ch2_last",  rsp_dat_r, 32'hA);

        // Fill channel 0, overflow attempt, pop the top.
        for (int i = 0; i < N; i++) do_cmd(0, 2'b00, 32'h100 + 32'(i));
        chk("ch0_full16", 32'(full_r[0]), 32'd1);
        chk("ch0_cnt16",  32'(cnt_r[CW-1:0]), 32'd16);
        do_cmd(0, 2'b00, 32'hDEAD);
        chk("ch0_cnt_hold", 32'(cnt_r[CW-1:0]), 32'd16);
        do_cmd(0, 2'b01, 0);
        idle(1);
        chk("ch0_top",    rsp_dat_r, 32'h10F);
        chk("ch0_notful", 32'(full_r[0]), 32'd0);
        do_cmd(0, 2'b10, 0);

        // Pop from empty channel 1.
        do_cmd(1, 2'b01, 0);
        idle(2);

        // Interleaved channels.
        do_cmd(0, 2'b00, 32'h11);
        do_cmd(3, 2'b00, 32'h33);
        do_cmd(0, 2'b01, 0);
        do_cmd(3, 2'b01, 0);
        idle(2);
        held = rsp_dat_r;
        chk("rsp_hold", held, 32'h33);

        // Pop then push reuses the vacated slot.
        do_cmd(2, 2'b00, 32'h1);
        do_cmd(2, 2'b00, 32'h2);
        do_cmd(2, 2'b01, 0);
        do_cmd(2, 2'b00, 32'h9);
        do_cmd(2, 2'b01, 0);
        do_cmd(2, 2'b01, 0);
        idle(2);

        // Clear then reuse, clear on empty.
        for (int i = 0; i < 5; i++) do_cmd(1, 2'b00, 32'h50 + 32'(i));
        do_cmd(1, 2'b10, 0);
        do_cmd(1, 2'b00, 32'h77);
        do_cmd(1, 2'b01, 0);
        idle(1);
        chk("clr_dat",   rsp_dat_r, 32'h77);
        chk("clr_empty", 32'(empty_r[1]), 32'd1);
        do_cmd(1, 2'b10, 0);

        // Reset with data in flight on several channels.
        do_cmd(3, 2'b00, 32'hE1);
        do_cmd(3, 2'b00, 32'hE2);
        do_cmd(1, 2'b00, 32'hE3);
        do_reset();
        do_cmd(3, 2'b01, 0);
        idle(1);

        // Op 11: peek when enabled, otherwise always an error.
        do_cmd(2, 2'b00, 32'h5);
        do_cmd(2, 2'b11, 0);
        do_cmd(2, 2'b11, 0);
`ifdef QS_STACK_MC_PEEK_EN
        chk("peek_cnt", 32'(cnt_r[2*CW +: CW]), 32'd1);
`else
        chk("op11_cnt", 32'(cnt_r[2*CW +: CW]), 32'd1);
`endif
        do_cmd(2, 2'b01, 0);
        do_cmd(2, 2'b11, 0);
        idle(3);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
